issue_queue_alu: RTL and testbench
==================================

Name: issue_queue_alu

Overview:
- Age-ordered, compacting issue queue for one single-cycle ALU pipe.
- Holds renamed uops until both source physical registers are ready, then selects the oldest ready entry per cycle.
- Outputs feed the issue-to-register-file pipeline register directly; that register latches the issued uop on the next edge unless paused.
- Tracks operand readiness through writeback wakeup broadcasts and through self-wakeup from its own issued destination tags, which allows back-to-back issue of dependent ALU ops.

Parameters:
- DEPTH, 8: number of entries; power of two, at least 2.
- PRF_AW, 6: physical register address width.
- PAYLOAD_W, 64: opaque uop bits carried unchanged (opcode, imm, PC, ROB id).
- WAKE_N, 2: number of external wakeup broadcast ports.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; empties the queue.
- pause  in  1  downstream stall (includes the primary pause request); blocks dequeue.
- enq_valid  in  1  rename offers a uop.
- enq_ready  out  1  queue can accept a uop this cycle.
- enq_payload  in  PAYLOAD_W  uop body.
- enq_op0_paddr, enq_op1_paddr  in  PRF_AW each  source tags.
- enq_op0_rdy, enq_op1_rdy  in  1 each  source ready at rename.
- enq_dst_paddr  in  PRF_AW  destination tag.
- enq_dst_wen  in  1  uop writes a register.
- wake_valid  in  WAKE_N  per-port broadcast valid.
- wake_paddr  in  WAKE_N*PRF_AW  broadcast tags; port k uses bits [k*PRF_AW +: PRF_AW].
- iss_valid  out  1  selected uop is valid.
- iss_payload  out  PAYLOAD_W  selected payload.
- iss_op0_paddr, iss_op1_paddr  out  PRF_AW each  register-file read addresses.
- iss_dst_paddr  out  PRF_AW  destination tag.
- iss_dst_wen  out  1  destination write enable.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and reset
  - Entries 0..count-1 are valid; index 0 is oldest.
  - Async reset clears all valid and ready bits; count=0, iss_valid=0, all iss_* outputs 0, enq_ready=1.
- Handshakes
  - enq_ready = (count != DEPTH). It does not account for a same-cycle dequeue.
  - Enqueue fires when enq_valid && enq_ready.
  - Dequeue fires when iss_valid && !pause.
- Select (combinational)
  - iss_valid = OR over valid entries with op0_rdy && op1_rdy.
  - The selected entry is the lowest such index.
  - iss_* fields come from that entry; they are 0 when iss_valid=0.
- Clock edge, priority order
  1. flush: count=0, all valid bits cleared; enqueue and dequeue are ignored that cycle.
  2. Dequeue: entries above the selected index shift down by one.
  3. Enqueue: the new entry is written at index count minus (1 if dequeue else 0).
  4. count = count + enq - deq, which is bounded to 0..DEPTH.
- Wakeup
  - A source ready bit is set on the edge when any wake_valid[k] has wake_paddr[k] equal to its tag.
  - It is also set when a dequeue fires with iss_dst_wen=1 and iss_dst_paddr equal to its tag (self-wakeup).
  - Wakeup applies to entries being shifted and to the entry being enqueued that same cycle, so there is no missed-wakeup window.
  - Ready bits never clear except on flush or reset.
- Pause
  - No dequeue and no shift; iss_* hold stable as long as readiness does not promote an older entry.
  - Enqueue and wakeup continue during pause.
  - When pause deasserts, the current oldest-ready entry issues.
- Boundary cases
  - Full queue with a simultaneous dequeue: enq_ready stays 0 and no enqueue occurs.
  - Empty queue with a ready enqueue: the uop is visible on iss_* the cycle after enqueue. Minimum latency is 1.
  - A tag match on a source already ready has no effect.
  - Both sources equal to the same tag: both bits set together.
  - flush asserted together with pause: flush wins.

Test Plan:
- Reset, then enqueue A (both sources ready, dst=5) -> next cycle iss_valid=1 with A's fields; with pause=0, count returns 0 on the following edge.
- Enqueue A (dst=5, ready) then B (op0=5 not ready, op1 ready) on consecutive cycles, pause=0 -> A issues in cycle n, B issues in cycle n+1 via self-wakeup. No bubble.
- Fill 8 entries all waiting on tag 9 -> enq_ready=0, count=8. Pulse wake_valid[1] with tag 9 -> entries 0..7 issue in age order over 8 cycles; enq_ready rises after the first dequeue.
- Ready entries at indexes 0 and 2 with pause held 3 cycles -> iss_* stay on entry 0 and count is unchanged. After release, entries 0 then 2 issue.
- Wakeup of tag 12 in the same cycle as enqueue of a uop with op1=12, op1_rdy=0 -> the entry is stored ready and issues the next cycle.
- Queue holding 4 entries: flush with enq_valid=1 -> count=0 and iss_valid=0 next cycle. Then assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_queue_alu.sv
// Age-ordered, compacting issue queue for a single-cycle ALU pipe.
// Picks the oldest entry whose sources are ready; wakeup comes from writeback and self-issue.
module issue_queue_alu #(
  parameter int DEPTH     = 8,
  parameter int PRF_AW    = 6,
  parameter int PAYLOAD_W = 64,
  parameter int WAKE_N    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       pause,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [PRF_AW-1:0]          enq_op0_paddr,
  input  logic [PRF_AW-1:0]          enq_op1_paddr,
  input  logic                       enq_op0_rdy,
  input  logic                       enq_op1_rdy,
  input  logic [PRF_AW-1:0]          enq_dst_paddr,
  input  logic                       enq_dst_wen,
  input  logic [WAKE_N-1:0]          wake_valid,
  input  logic [WAKE_N*PRF_AW-1:0]   wake_paddr,
  output logic                       iss_valid,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [PRF_AW-1:0]          iss_op0_paddr,
  output logic [PRF_AW-1:0]          iss_op1_paddr,
  output logic [PRF_AW-1:0]          iss_dst_paddr,
  output logic                       iss_dst_wen,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [PRF_AW-1:0]    op0_q     [DEPTH];
  logic [PRF_AW-1:0]    op0_d     [DEPTH];
  logic [PRF_AW-1:0]    op1_q     [DEPTH];
  logic [PRF_AW-1:0]    op1_d     [DEPTH];
  logic [PRF_AW-1:0]    dst_q     [DEPTH];
  logic [PRF_AW-1:0]    dst_d     [DEPTH];
  logic [DEPTH-1:0]     dst_wen_q, dst_wen_d;
  logic [DEPTH-1:0]     op0_rdy_q, op0_rdy_d;
  logic [DEPTH-1:0]     op1_rdy_q, op1_rdy_d;
  logic [CW-1:0]        count_q, count_d;

  logic [DEPTH-1:0]     ready_vec;
  logic [DEPTH-1:0]     wake0, wake1;
  logic                 enq_wake0, enq_wake1;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        src_idx;
  logic [CW-1:0]        wr_idx;
  logic                 do_deq, do_enq;

  assign count     = count_q;
  assign enq_ready = (count_q != CW'(DEPTH));
  assign do_deq    = iss_valid & ~pause & ~flush;
  assign do_enq    = enq_valid & enq_ready & ~flush;

  // Oldest-ready select: the lowest valid index with both sources ready wins.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = (CW'(i) < count_q) & op0_rdy_q[i] & op1_rdy_q[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel_idx = IW'(i);
    end
    iss_valid     = |ready_vec;
    iss_payload   = iss_valid ? payload_q[sel_idx] : '0;
    iss_op0_paddr = iss_valid ? op0_q[sel_idx]     : '0;
    iss_op1_paddr = iss_valid ? op1_q[sel_idx]     : '0;
    iss_dst_paddr = iss_valid ? dst_q[sel_idx]     : '0;
    iss_dst_wen   = iss_valid & dst_wen_q[sel_idx];
  end

  // Tag matches against writeback broadcasts plus the uop issuing this cycle.
  always_comb begin
    wake0     = '0;
    wake1     = '0;
    enq_wake0 = 1'b0;
    enq_wake1 = 1'b0;
    for (int k = 0; k < WAKE_N; k++) begin
      if (wake_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wake_paddr[k*PRF_AW +: PRF_AW] == op0_q[i]) wake0[i] = 1'b1;
          if (wake_paddr[k*PRF_AW +: PRF_AW] == op1_q[i]) wake1[i] = 1'b1;
        end
        if (wake_paddr[k*PRF_AW +: PRF_AW] == enq_op0_paddr) enq_wake0 = 1'b1;
        if (wake_paddr[k*PRF_AW +: PRF_AW] == enq_op1_paddr) enq_wake1 = 1'b1;
      end
    end
    if (do_deq && iss_dst_wen) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (iss_dst_paddr == op0_q[i]) wake0[i] = 1'b1;
        if (iss_dst_paddr == op1_q[i]) wake1[i] = 1'b1;
      end
      if (iss_dst_paddr == enq_op0_paddr) enq_wake0 = 1'b1;
      if (iss_dst_paddr == enq_op1_paddr) enq_wake1 = 1'b1;
    end
  end

  // Next state: compact over the issued slot, then append at the new tail.
  always_comb begin
    count_d = count_q + CW'(do_enq) - CW'(do_deq);
    wr_idx  = count_q - CW'(do_deq);
    src_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_deq && (i >= int'(sel_idx)) && (i < DEPTH - 1)) src_idx = IW'(i + 1);
      else                                                    src_idx = IW'(i);
      payload_d[i] = payload_q[src_idx];
      op0_d[i]     = op0_q[src_idx];
      op1_d[i]     = op1_q[src_idx];
      dst_d[i]     = dst_q[src_idx];
      dst_wen_d[i] = dst_wen_q[src_idx];
      op0_rdy_d[i] = op0_rdy_q[src_idx] | wake0[src_idx];
      op1_rdy_d[i] = op1_rdy_q[src_idx] | wake1[src_idx];
      if (do_enq && (wr_idx[IW-1:0] == IW'(i))) begin
        payload_d[i] = enq_payload;
        op0_d[i]     = enq_op0_paddr;
        op1_d[i]     = enq_op1_paddr;
        dst_d[i]     = enq_dst_paddr;
        dst_wen_d[i] = enq_dst_wen;
        op0_rdy_d[i] = enq_op0_rdy | enq_wake0;
        op1_rdy_d[i] = enq_op1_rdy | enq_wake1;
      end
    end
    if (flush) begin
      count_d   = '0;
      op0_rdy_d = '0;
      op1_rdy_d = '0;
    end
  end

  // NOTE: sequential state is assigned with non-blocking <= so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      op0_rdy_q <= '0;
      op1_rdy_q <= '0;
    end else begin
      count_q   <= count_d;
      op0_rdy_q <= op0_rdy_d;
      op1_rdy_q <= op1_rdy_d;
    end
  end

  // NOTE: entry storage has no reset; validity is defined solely by count_q and iss_* are gated.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
    op0_q     <= op0_d;
    op1_q     <= op1_d;
    dst_q     <= dst_d;
    dst_wen_q <= dst_wen_d;
  end

endmodule

// File: tb/tb_issue_queue_alu.sv
// Directed bench for issue_queue_alu: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_issue_queue_alu;

  logic        clk = 1'b0;
  logic        rst, flush, pause;
  logic        enq_valid, enq_ready;
  logic [63:0] enq_payload;
  logic [5:0]  enq_op0_paddr, enq_op1_paddr, enq_dst_paddr;
  logic        enq_op0_rdy, enq_op1_rdy, enq_dst_wen;
  logic [1:0]  wake_valid;
  logic [11:0] wake_paddr;
  logic        iss_valid;
  logic [63:0] iss_payload;
  logic [5:0]  iss_op0_paddr, iss_op1_paddr, iss_dst_paddr;
  logic        iss_dst_wen;
  logic [3:0]  count;

  int checks = 0;
  int passed = 0;

  issue_queue_alu dut (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
    .enq_op0_paddr(enq_op0_paddr), .enq_op1_paddr(enq_op1_paddr),
    .enq_op0_rdy(enq_op0_rdy), .enq_op1_rdy(enq_op1_rdy),
    .enq_dst_paddr(enq_dst_paddr), .enq_dst_wen(enq_dst_wen),
    .wake_valid(wake_valid), .wake_paddr(wake_paddr),
    .iss_valid(iss_valid), .iss_payload(iss_payload),
    .iss_op0_paddr(iss_op0_paddr), .iss_op1_paddr(iss_op1_paddr),
    .iss_dst_paddr(iss_dst_paddr), .iss_dst_wen(iss_dst_wen),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no summary expected one");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; pause = 0; enq_valid = 0; enq_payload = '0;
    enq_op0_paddr = '0; enq_op1_paddr = '0; enq_op0_rdy = 0; enq_op1_rdy = 0;
    enq_dst_paddr = '0; enq_dst_wen = 0; wake_valid = '0; wake_paddr = '0;
  endtask

  // NOTE: stimulus is driven with blocking assignments at posedge+1, well clear of the sampling edge.
  task automatic drive_enq(input logic [63:0] pl, input logic [5:0] a, input logic ra,
                           input logic [5:0] b, input logic rb, input logic [5:0] d,
                           input logic w);
    enq_valid = 1; enq_payload = pl; enq_op0_paddr = a; enq_op0_rdy = ra;
    enq_op1_paddr = b; enq_op1_rdy = rb; enq_dst_paddr = d; enq_dst_wen = w;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs();
    step(); step();
    checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
    checks++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid: got %b expected 0", iss_valid); else passed++;
    checks++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); else passed++;
    checks++; if (iss_payload !== 64'd0) $display("FAIL reset_iss_payload: got %h expected 0", iss_payload); else passed++;
    rst = 0;
    step();
  endtask

  task automatic test_single_issue;
    drive_enq(64'hA, 6'd1, 1, 6'd2, 1, 6'd5, 1);
    step();
    enq_valid = 0;
    checks++; if (iss_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", iss_valid); else passed++;
    checks++; if (iss_payload !== 64'hA) $display("FAIL single_payload: got %h expected a", iss_payload); else passed++;
    checks++; if (iss_op0_paddr !== 6'd1 || iss_op1_paddr !== 6'd2)
      $display("FAIL single_srcs: got %0d/%0d expected 1/2", iss_op0_paddr, iss_op1_paddr); else passed++;
    checks++; if (iss_dst_paddr !== 6'd5 || iss_dst_wen !== 1'b1)
      $display("FAIL single_dst: got %0d/%b expected 5/1", iss_dst_paddr, iss_dst_wen); else passed++;
    checks++; if (count !== 4'd1) $display("FAIL single_count1: got %0d expected 1", count); else passed++;
    step();
    checks++; if (count !== 4'd0 || iss_valid !== 1'b0)
      $display("FAIL single_drain: got count %0d valid %b expected 0/0", count, iss_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    drive_enq(64'hA0, 6'd1, 1, 6'd2, 1, 6'd5, 1);
    step();
    drive_enq(64'hB0, 6'd5, 0, 6'd6, 1, 6'd7, 1);
    checks++; if (iss_payload !== 64'hA0) $display("FAIL b2b_first: got %h expected a0", iss_payload); else passed++;
    step();
    enq_valid = 0;
    checks++; if (iss_valid !== 1'b1 || iss_payload !== 64'hB0)
      $display("FAIL b2b_second: got valid %b payload %h expected 1/b0", iss_valid, iss_payload); else passed++;
    checks++; if (iss_op0_paddr !== 6'd5) $display("FAIL b2b_op0: got %0d expected 5", iss_op0_paddr); else passed++;
    step();
    checks++; if (count !== 4'd0) $display("FAIL b2b_drain: got %0d expected 0", count); else passed++;
  endtask

  task automatic test_fill_and_wake;
    for (int i = 0; i < 8; i++) begin
      drive_enq(64'h100 + 64'(i), 6'd9, 0, 6'(i + 1), 1, 6'(20 + i), 1);
      step();
    end
    checks++; if (count !== 4'd8 || enq_ready !== 1'b0)
      $display("FAIL fill_full: got count %0d ready %b expected 8/0", count, enq_ready); else passed++;
    checks++; if (iss_valid !== 1'b0) $display("FAIL fill_blocked: got %b expected 0", iss_valid); else passed++;
    drive_enq(64'hDEAD, 6'd1, 1, 6'd1, 1, 6'd3, 0);
    wake_valid = 2'b10; wake_paddr = {6'd9, 6'd33};
    step();
    wake_valid = '0; wake_paddr = '0;
    checks++; if (count !== 4'd8 || iss_payload !== 64'h100 || enq_ready !== 1'b0)
      $display("FAIL fill_woken: got count %0d payload %h ready %b expected 8/100/0",
               count, iss_payload, enq_ready); else passed++;
    step();
    enq_valid = 0;
    checks++; if (count !== 4'd7 || enq_ready !== 1'b1)
      $display("FAIL fill_full_deq: got count %0d ready %b expected 7/1", count, enq_ready); else passed++;
    for (int i = 1; i < 8; i++) begin
      checks++; if (iss_valid !== 1'b1 || iss_payload !== 64'h100 + 64'(i))
        $display("FAIL fill_order%0d: got valid %b payload %h expected 1/%h",
                 i, iss_valid, iss_payload, 64'h100 + 64'(i)); else passed++;
      step();
    end
    checks++; if (count !== 4'd0) $display("FAIL fill_drain: got %0d expected 0", count); else passed++;
  endtask

  task automatic test_pause_and_flush;
    pause = 1;
    drive_enq(64'h200, 6'd1, 1, 6'd2, 1, 6'd31, 1); step();
    drive_enq(64'h201, 6'd30, 0, 6'd2, 1, 6'd32, 1); step();
    drive_enq(64'h202, 6'd3, 1, 6'd4, 1, 6'd33, 0); step();
    enq_valid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (iss_payload !== 64'h200 || count !== 4'd3)
        $display("FAIL pause_hold%0d: got payload %h count %0d expected 200/3", c, iss_payload, count); else passed++;
      step();
    end
    pause = 0;
    checks++; if (iss_payload !== 64'h200) $display("FAIL pause_rel0: got %h expected 200", iss_payload); else passed++;
    step();
    checks++; if (iss_payload !== 64'h202) $display("FAIL pause_rel2: got %h expected 202", iss_payload); else passed++;
    step();
    checks++; if (count !== 4'd1 || iss_valid !== 1'b0)
      $display("FAIL pause_left: got count %0d valid %b expected 1/0", count, iss_valid); else passed++;
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      drive_enq(64'h210 + 64'(i), 6'd1, 1, 6'd1, 1, 6'd2, 1);
      step();
    end
    checks++; if (count !== 4'd4) $display("FAIL flush_pre: got %0d expected 4", count); else passed++;
    flush = 1;
    step();
    flush = 0; enq_valid = 0; pause = 0;
    checks++; if (count !== 4'd0 || iss_valid !== 1'b0)
      $display("FAIL flush_empty: got count %0d valid %b expected 0/0", count, iss_valid); else passed++;
  endtask

  task automatic test_wake_on_enq;
    drive_enq(64'h300, 6'd3, 1, 6'd12, 0, 6'd40, 0);
    wake_valid = 2'b01; wake_paddr = {6'd50, 6'd12};
    step();
    enq_valid = 0; wake_valid = '0;
    checks++; if (iss_valid !== 1'b1 || iss_payload !== 64'h300 || iss_op1_paddr !== 6'd12)
      $display("FAIL wake_enq: got valid %b payload %h op1 %0d expected 1/300/12",
               iss_valid, iss_payload, iss_op1_paddr); else passed++;
    step();
    drive_enq(64'h400, 6'd44, 0, 6'd44, 0, 6'd45, 1);
    step();
    enq_valid = 0;
    checks++; if (iss_valid !== 1'b0 || count !== 4'd1)
      $display("FAIL same_tag_wait: got valid %b count %0d expected 0/1", iss_valid, count); else passed++;
    wake_valid = 2'b01; wake_paddr = {6'd0, 6'd44};
    step();
    wake_valid = '0;
    checks++; if (iss_valid !== 1'b1 || iss_payload !== 64'h400)
      $display("FAIL same_tag_wake: got valid %b payload %h expected 1/400", iss_valid, iss_payload); else passed++;
    step();
  endtask

  task automatic test_async_reset;
    pause = 1;
    drive_enq(64'h500, 6'd1, 1, 6'd2, 1, 6'd3, 1); step();
    drive_enq(64'h501, 6'd1, 1, 6'd2, 1, 6'd3, 1); step();
    enq_valid = 0;
    checks++; if (count !== 4'd2 || iss_valid !== 1'b1)
      $display("FAIL arst_pre: got count %0d valid %b expected 2/1", count, iss_valid); else passed++;
    #2 rst = 1;
    #1;
    checks++; if (count !== 4'd0 || iss_valid !== 1'b0 || iss_payload !== 64'd0 || enq_ready !== 1'b1)
      $display("FAIL arst_now: got count %0d valid %b payload %h ready %b expected 0/0/0/1",
               count, iss_valid, iss_payload, enq_ready); else passed++;
    step();
    rst = 0; pause = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_fill_and_wake();
    test_pause_and_flush();
    test_wake_on_enq();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
